// File: rtl/fifo_rd_stream_adapter_pkg.sv
// Shared types and sizing for the FIFO read-side stream adapter.
// D_DATA_WIDTH may be predefined to set the default word width.
`ifndef D_DATA_WIDTH
`define D_DATA_WIDTH 8
`endif

package fifo_package;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ONE,
    ST_FULL
  } fifo_rd_state_e;

  localparam int FIFO_RD_BUF_DEPTH = 2;
  localparam int FIFO_RD_OCC_WIDTH = $clog2(FIFO_RD_BUF_DEPTH + 1);

endpackage

// File: rtl/fifo_rd_stream_adapter_skid_buf.sv
// Two-entry head/tail register buffer; head is always the word presented downstream.
//
//  state    | meaning
//  ST_EMPTY | nothing buffered, output invalid
//  ST_ONE   | head holds the output word, tail unused
//  ST_FULL  | head holds the output word, tail holds the next word
module fifo_rd_skid_buf
  import fifo_package::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic [DATA_WIDTH-1:0]        din,
  output logic                         valid,
  output logic [DATA_WIDTH-1:0]        head,
  output logic [FIFO_RD_OCC_WIDTH-1:0] occ
);

  fifo_rd_state_e        state;
  fifo_rd_state_e        state_nxt;
  logic [DATA_WIDTH-1:0] head_nxt;
  logic [DATA_WIDTH-1:0] tail;
  logic [DATA_WIDTH-1:0] tail_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_EMPTY;
      head  <= '0;
      tail  <= '0;
    end else begin
      state <= state_nxt;
      head  <= head_nxt;
      tail  <= tail_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    head_nxt  = head;
    tail_nxt  = tail;
    case (state)
      ST_EMPTY: begin
        if (push) begin
          state_nxt = ST_ONE;
          head_nxt  = din;
        end
      end
      ST_ONE: begin
        if (push && !pop) begin
          state_nxt = ST_FULL;
          tail_nxt  = din;
        end else if (!push && pop) begin
          state_nxt = ST_EMPTY;
        end else if (push && pop) begin
          head_nxt = din;
        end
      end
      ST_FULL: begin
        // Credit logic upstream never lets a push arrive here without a pop.
        if (pop) begin
          head_nxt = tail;
          if (push) tail_nxt = din;
          else state_nxt = ST_ONE;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end

  always_comb begin
    occ = '0;
    case (state)
      ST_ONE:  occ = FIFO_RD_OCC_WIDTH'(1);
      ST_FULL: occ = FIFO_RD_OCC_WIDTH'(FIFO_RD_BUF_DEPTH);
      default: occ = '0;
    endcase
  end

  assign valid = (state != ST_EMPTY);

  a_full_push_needs_pop: assert property (@(posedge clk) disable iff (!rst_n)
    !(state == ST_FULL && push && !pop));

endmodule

// File: rtl/fifo_rd_stream_adapter.sv
// Drains a 1-cycle-latency sync FIFO into a valid/ready stream at up to 1 word/clk.
// Optional feature macro FIFO_RD_ADAPT_CNT_EN adds CNT_WIDTH and the xfer_cnt handshake counter.
`ifndef D_DATA_WIDTH
`define D_DATA_WIDTH 8
`endif

module fifo_rd_stream_adapter
  import fifo_package::*;
#(
  parameter int DATA_WIDTH = `D_DATA_WIDTH
`ifdef FIFO_RD_ADAPT_CNT_EN
  ,
  parameter int CNT_WIDTH  = 16
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data
`ifdef FIFO_RD_ADAPT_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  xfer_cnt
`endif
);

  logic                         inflight;
  logic                         pop;
  logic [FIFO_RD_OCC_WIDTH-1:0] occ;
  logic [2:0]                   used;
  logic [2:0]                   limit;

  assign pop = m_valid & m_ready;

  // Buffered words plus the one in flight must leave room, counting this cycle's pop.
  assign used       = 3'(occ) + 3'(inflight);
  assign limit      = 3'(FIFO_RD_BUF_DEPTH) + 3'(pop);
  assign fifo_rd_en = rst_n & ~fifo_empty & (used < limit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) inflight <= 1'b0;
    else        inflight <= fifo_rd_en;
  end

  fifo_rd_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid_buf (
    .clk  (clk),
    .rst_n(rst_n),
    .push (inflight),
    .pop  (pop),
    .din  (fifo_dout),
    .valid(m_valid),
    .head (m_data),
    .occ  (occ)
  );

`ifdef FIFO_RD_ADAPT_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   xfer_cnt <= '0;
    else if (pop) xfer_cnt <= xfer_cnt + CNT_WIDTH'(1);
  end
`endif

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Directed bench for fifo_rd_stream_adapter with a behavioural 1-cycle-latency FIFO.
// Honours FIFO_RD_ADAPT_CNT_EN (counter width 4 when enabled).
`timescale 1ns/1ps

module tb_fifo_rd_stream_adapter;

  localparam int DW = 8;
`ifdef FIFO_RD_ADAPT_CNT_EN
  localparam int CW = 4;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fifo_rst_n = 1'b0;
  logic          fifo_empty;
  logic [DW-1:0] fifo_dout;
  logic          fifo_rd_en;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
`ifdef FIFO_RD_ADAPT_CNT_EN
  logic [CW-1:0] xfer_cnt;
  logic [CW-1:0] cnt_model = '0;
`endif

  int            checks = 0;
  int            failures = 0;
  int            uflow = 0;
  int            beats = 0;
  logic          held_v = 1'b0;
  logic [DW-1:0] held_d = '0;
  logic [DW-1:0] fq[$];
  logic [DW-1:0] exp_q[$];

  typedef struct packed {
    logic          wr;
    logic [DW-1:0] d;
    logic          rdy;
    logic          e_rd;
    logic          e_v;
    logic [DW-1:0] e_data;
  } vec_t;

  vec_t tbl[10];

  always #5 clk = ~clk;

  fifo_rd_stream_adapter #(
    .DATA_WIDTH(DW)
`ifdef FIFO_RD_ADAPT_CNT_EN
    ,
    .CNT_WIDTH (CW)
`endif
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .fifo_empty(fifo_empty),
    .fifo_dout (fifo_dout),
    .fifo_rd_en(fifo_rd_en),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data)
`ifdef FIFO_RD_ADAPT_CNT_EN
    ,
    .xfer_cnt  (xfer_cnt)
`endif
  );

  // Behavioural sync FIFO: dout valid the cycle after a pop, registered empty flag.
  always @(posedge clk or negedge fifo_rst_n) begin
    if (!fifo_rst_n) begin
      fq.delete();
      fifo_dout  <= '0;
      fifo_empty <= 1'b1;
    end else begin
      if (fifo_rd_en && fq.size() > 0) fifo_dout <= fq.pop_front();
      if (wr_en) fq.push_back(wr_data);
      fifo_empty <= (fq.size() == 0);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic mon();
    logic [DW-1:0] e;
    if (!rst_n) begin
      held_v = 1'b0;
      return;
    end
    if (fifo_rd_en && fifo_empty) uflow++;
    if (held_v) begin
      chk("hold_valid", {31'd0, m_valid}, 32'd1);
      chk("hold_data", {24'd0, m_data}, {24'd0, held_d});
    end
`ifdef FIFO_RD_ADAPT_CNT_EN
    chk("xfer_cnt", {28'd0, xfer_cnt}, {28'd0, cnt_model});
`endif
    if (m_valid && m_ready) begin
      chk("beat_expected", {31'd0, exp_q.size() > 0}, 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("beat_data", {24'd0, m_data}, {24'd0, e});
      end
      beats++;
`ifdef FIFO_RD_ADAPT_CNT_EN
      cnt_model = cnt_model + 1'b1;
`endif
    end
    held_v = m_valid && !m_ready;
    held_d = m_data;
  endtask

  task automatic cycle(input logic wr, input logic [DW-1:0] d, input logic rdy);
    @(posedge clk);
    #1;
    wr_en   = wr;
    wr_data = d;
    m_ready = rdy;
    if (wr && fifo_rst_n) exp_q.push_back(d);
    @(negedge clk);
    mon();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n      = 1'b0;
    fifo_rst_n = 1'b0;
    wr_en      = 1'b0;
    m_ready    = 1'b0;
    exp_q.delete();
    held_v     = 1'b0;
`ifdef FIFO_RD_ADAPT_CNT_EN
    cnt_model  = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    rst_n      = 1'b1;
    fifo_rst_n = 1'b1;
  endtask

  initial begin
    int   first_rd;
    int   first_v;
    int   last_beat;
    int   gaps;
    int   nbeat;
    int   npop;
    int   written;
    logic w;
    logic tmo;

    //        wr    d      rdy   e_rd  e_v   e_data
    tbl[0] = {1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[1] = {1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 8'h00};
    tbl[2] = {1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 8'h00};
    tbl[3] = {1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h11};
    tbl[4] = {1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h11};
    tbl[5] = {1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h11};
    tbl[6] = {1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h22};
    tbl[7] = {1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h33};
    tbl[8] = {1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h33};
    tbl[9] = {1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h33};

    // Power-on reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("por_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    chk("por_m_valid", {31'd0, m_valid}, 32'd0);
    chk("por_m_data", {24'd0, m_data}, 32'd0);
    @(posedge clk);
    #1;
    rst_n      = 1'b1;
    fifo_rst_n = 1'b1;

    // Cycle-exact table: fill, back-pressure, combinational m_ready credit, drain
    for (int i = 0; i < 10; i++) begin
      cycle(tbl[i].wr, tbl[i].d, tbl[i].rdy);
      chk($sformatf("tbl%0d_rd_en", i), {31'd0, fifo_rd_en}, {31'd0, tbl[i].e_rd});
      chk($sformatf("tbl%0d_m_valid", i), {31'd0, m_valid}, {31'd0, tbl[i].e_v});
      chk($sformatf("tbl%0d_m_data", i), {24'd0, m_data}, {24'd0, tbl[i].e_data});
    end

    // Reset while the FIFO still holds 4 words: rd_en must stay low
    for (int k = 0; k < 9; k++) cycle(k < 6, DW'(8'h40 + k), 1'b0);
    chk("rst4_fifo_level", fq.size(), 32'd4);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst4_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    chk("rst4_m_valid", {31'd0, m_valid}, 32'd0);
    chk("rst4_m_data", {24'd0, m_data}, 32'd0);
`ifdef FIFO_RD_ADAPT_CNT_EN
    chk("rst4_xfer_cnt", {28'd0, xfer_cnt}, 32'd0);
`endif
    @(negedge clk);
    chk("rst4_rd_en_held", {31'd0, fifo_rd_en}, 32'd0);
    do_reset();

    // Streaming 16 words with m_ready high
    first_rd = -1; first_v = -1; last_beat = -1; gaps = 0; nbeat = 0;
    for (int k = 0; k < 25; k++) begin
      cycle(k < 16, DW'(k), 1'b1);
      if (fifo_rd_en && first_rd < 0) first_rd = k;
      if (m_valid && first_v < 0) first_v = k;
      if (m_valid && m_ready) begin
        if (last_beat >= 0 && k != last_beat + 1) gaps++;
        last_beat = k;
        nbeat++;
      end
    end
    chk("stream_first_valid_latency", first_v - first_rd, 32'd2);
    chk("stream_beats", nbeat, 32'd16);
    chk("stream_gaps", gaps, 32'd0);

    // Back-pressure: 8 words with the consumer stalled
    npop = 0;
    for (int k = 0; k < 18; k++) begin
      cycle(k < 8, DW'(k), 1'b0);
      if (fifo_rd_en) npop++;
    end
    chk("bp_pops", npop, 32'd2);
    chk("bp_m_valid", {31'd0, m_valid}, 32'd1);
    chk("bp_m_data", {24'd0, m_data}, 32'd0);
    chk("bp_fifo_level", fq.size(), 32'd6);
    nbeat = beats;
    for (int k = 0; k < 14; k++) cycle(1'b0, '0, 1'b1);
    chk("bp_release_beats", beats - nbeat, 32'd8);
    chk("bp_left", exp_q.size(), 32'd0);

    // Random m_ready, 256 random words
    written = 0;
    tmo = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      w = (written < 256);
      cycle(w, DW'($urandom_range(0, 255)), $urandom_range(0, 1) == 1);
      if (w) written++;
      if (written == 256 && exp_q.size() == 0) begin
        tmo = 1'b0;
        break;
      end
    end
    chk("rand_timeout", {31'd0, tmo}, 32'd0);
    chk("rand_left", exp_q.size(), 32'd0);
    for (int k = 0; k < 4; k++) cycle(1'b0, '0, 1'b1);

    // Reset in the middle of a 10-word burst
    nbeat = beats;
    tmo = 1'b1;
    for (int k = 0; k < 40; k++) begin
      cycle(k < 10, DW'(8'h60 + k), 1'b1);
      if (beats - nbeat == 5) begin
        tmo = 1'b0;
        break;
      end
    end
    chk("mid_reach_beat5", {31'd0, tmo}, 32'd0);
    @(posedge clk);
    #1;
    rst_n      = 1'b0;
    fifo_rst_n = 1'b0;
    wr_en      = 1'b0;
    #1;
    chk("mid_rst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("mid_rst_m_data", {24'd0, m_data}, 32'd0);
    chk("mid_rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
`ifdef FIFO_RD_ADAPT_CNT_EN
    chk("mid_rst_xfer_cnt", {28'd0, xfer_cnt}, 32'd0);
`endif
    do_reset();
    nbeat = beats;
    for (int k = 0; k < 12; k++) cycle(k < 4, DW'(8'hA0 + k), 1'b1);
    chk("post_rst_beats", beats - nbeat, 32'd4);
    chk("post_rst_left", exp_q.size(), 32'd0);

`ifdef FIFO_RD_ADAPT_CNT_EN
    // 18 handshakes on a 4-bit counter wrap through 0 and end at 2
    do_reset();
    for (int k = 0; k < 26; k++) cycle(k < 18, DW'(k), 1'b1);
    chk("cnt_final", {28'd0, xfer_cnt}, 32'd2);
`endif

    chk("no_underflow", uflow, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
